// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg
// Shared definitions for the UART program loader: the frame parser state
// encoding, the frame marker/command byte values and the default inter-byte
// timeout. Imported by uart_loader and by anything that needs to speak
// the loader's frame protocol.
package uart_loader_pkg;

   // Frame parser states, one per byte position in the frame
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CMD    = 4'd1,
      ST_ADDR_H = 4'd2,
      ST_ADDR_L = 4'd3,
      ST_LEN_H  = 4'd4,
      ST_LEN_L  = 4'd5,
      ST_DATA_H = 4'd6,
      ST_DATA_L = 4'd7,
      ST_CSUM   = 4'd8
   } loader_state_e;

   localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
   localparam logic [7:0]  CMD_WRITE       = 8'h01;
   localparam logic [7:0]  CMD_RUN         = 8'h02;

   // 100 ms at 50 MHz between bytes inside a frame
   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd5_000_000;

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe
// Turns the uart_rx "ready" level (1 = idle, 0 = receiving) into a single
// cycle strobe on its rising edge, and holds the byte that arrived with it.
// Usable by any consumer sitting behind uart_rx.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   rx_ready_i  uart_rx ready level
//   rx_data_i   uart_rx data, valid on the cycle rx_ready_i rises
//   stb_o       one-cycle strobe, high in the cycle rx_ready_i rises
//   data_o      received byte; equals rx_data_i during the strobe and holds
//               that value afterwards
module uart_byte_strobe (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_ready_i,
   input  logic [7:0] rx_data_i,
   output logic       stb_o,
   output logic [7:0] data_o
);

   logic       ready_q;
   logic [7:0] data_q;

   // The previous-ready register resets to 1 so that a line that is already
   // idle coming out of reset does not look like a fresh rising edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_q <= 1'b1;
         data_q  <= 8'h00;
      end else begin
         ready_q <= rx_ready_i;
         if (stb_o) begin
            data_q <= rx_data_i;
         end
      end
   end

   // The strobe is combinational so the consumer can act on the byte in
   // the very cycle it becomes valid; the data path bypasses the capture
   // register during that cycle for the same reason.
   assign stb_o  = rx_ready_i & ~ready_q;
   assign data_o = stb_o ? rx_data_i : data_q;

endmodule

// File: rtl/uart_loader.sv
// uart_loader
// Frame-level controller behind uart_rx for the ONC-16 core. Parses
// SYNC, CMD, [ADDR_H ADDR_L LEN_H LEN_L {DATA_H DATA_L}*LEN], CSUM frames,
// writes 16-bit words into program memory, holds the CPU while a frame is
// being loaded, checks the 8-bit checksum (CMD through CSUM sums to zero)
// and pulses cpu_start after a good RUN frame.
//
// Ports:
//   clock_50M  system clock
//   rst        asynchronous active-high reset
//   rx_ready   uart_rx ready level (1 = idle, 0 = receiving)
//   rx_data    uart_rx data, valid on the cycle rx_ready rises
//   mem_we     one-cycle program memory write strobe
//   mem_addr   word address of the write
//   mem_wdata  word data of the write
//   cpu_hold   CPU stall while a frame is in progress
//   cpu_start  one-cycle run pulse
//   busy       parser is not idle
//   err        sticky error flag, cleared by the next SYNC seen while idle
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clock_50M,
   input  logic        rst,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_hold,
   output logic        cpu_start,
   output logic        busy,
   output logic        err
);

   logic          byte_stb;
   logic [7:0]    byte_data;

   loader_state_e state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    sum_q, sum_d;
   logic          is_run_q, is_run_d;
   logic [23:0]   timer_q, timer_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [15:0]   waddr_q, waddr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          start_q, start_d;

   logic [7:0]    sum_next;
   logic [15:0]   len_full;

   uart_byte_strobe u_strobe (
      .clk_i      (clock_50M),
      .rst_i      (rst),
      .rx_ready_i (rx_ready),
      .rx_data_i  (rx_data),
      .stb_o      (byte_stb),
      .data_o     (byte_data)
   );

   assign sum_next = sum_q + byte_data;
   assign len_full = {len_q[15:8], byte_data};

   // State and datapath registers; everything returns to idle/zero on reset
   // so a reset mid-frame drops the hold and any pending write at once.
   always_ff @(posedge clock_50M or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= 16'h0000;
         len_q    <= 16'h0000;
         hi_q     <= 8'h00;
         sum_q    <= 8'h00;
         is_run_q <= 1'b0;
         timer_q  <= 24'd0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= 16'h0000;
         wdata_q  <= 16'h0000;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         hi_q     <= hi_d;
         sum_q    <= sum_d;
         is_run_q <= is_run_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         start_q  <= start_d;
      end
   end

   // Frame parser. Every transition happens on a byte strobe, except the
   // timeout abort which fires when no byte has arrived for TIMEOUT clocks
   // while a frame is open. The checksum accumulator restarts on the CMD
   // byte so SYNC never contributes to it.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      hi_d     = hi_q;
      sum_d    = sum_q;
      is_run_d = is_run_q;
      err_d    = err_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      start_d  = 1'b0;

      if (state_q == ST_IDLE || byte_stb) begin
         timer_d = 24'd0;
      end else begin
         timer_d = timer_q + 24'd1;
      end

      if (byte_stb) begin
         case (state_q)
            ST_IDLE: begin
               if (byte_data == SYNC_BYTE) begin
                  state_d = ST_CMD;
                  err_d   = 1'b0;
               end
            end
            ST_CMD: begin
               sum_d = byte_data;
               if (byte_data == CMD_WRITE) begin
                  is_run_d = 1'b0;
                  state_d  = ST_ADDR_H;
               end else if (byte_data == CMD_RUN) begin
                  is_run_d = 1'b1;
                  state_d  = ST_CSUM;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR_H: begin
               sum_d         = sum_next;
               addr_d[15:8]  = byte_data;
               state_d       = ST_ADDR_L;
            end
            ST_ADDR_L: begin
               sum_d         = sum_next;
               addr_d[7:0]   = byte_data;
               state_d       = ST_LEN_H;
            end
            ST_LEN_H: begin
               sum_d         = sum_next;
               len_d[15:8]   = byte_data;
               state_d       = ST_LEN_L;
            end
            ST_LEN_L: begin
               sum_d = sum_next;
               len_d = len_full;
               if (len_full == 16'h0000) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA_H;
               end
            end
            ST_DATA_H: begin
               sum_d   = sum_next;
               hi_d    = byte_data;
               state_d = ST_DATA_L;
            end
            ST_DATA_L: begin
               // The word goes out from registers next cycle; the address
               // counter wraps naturally at 16 bits.
               sum_d   = sum_next;
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = {hi_q, byte_data};
               addr_d  = addr_q + 16'h0001;
               len_d   = len_q - 16'h0001;
               if (len_q == 16'h0001) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA_H;
               end
            end
            ST_CSUM: begin
               // Words already written stay written on a bad sum; the host
               // simply resends the whole frame.
               sum_d   = sum_next;
               state_d = ST_IDLE;
               if (sum_next == 8'h00) begin
                  start_d = is_run_q;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE && timer_q == TIMEOUT - 24'd1) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
   end

   // The CPU is held from the cycle after the command is accepted until the
   // parser is back in idle, so hold is already low when cpu_start fires.
   assign cpu_hold  = (state_q != ST_IDLE) && (state_q != ST_CMD);
   assign busy      = (state_q != ST_IDLE);
   assign err       = err_q;
   assign mem_we    = we_q;
   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;
   assign cpu_start = start_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader
// Directed bench for uart_loader with the inter-byte timeout shortened to
// 100 clocks. Bytes are presented the way uart_rx does it: ready drops for
// a few cycles, then rises with the byte on rx_data. A monitor on the
// falling clock edge records every memory write and every cpu_start pulse.
module tb_uart_loader;

   logic        clock_50M = 1'b0;
   logic        rst;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        cpu_start;
   logic        busy;
   logic        err;

   int          passCnt = 0;
   int          totalCnt = 0;

   logic [15:0] wAddr[$];
   logic [15:0] wData[$];
   int          startCnt = 0;
   int          startWithHold = 0;
   logic [7:0]  frm[$];
   int          idleActivity;
   int          startBefore;

   uart_loader #(.TIMEOUT(24'd100)) dut (
      .clock_50M (clock_50M),
      .rst       (rst),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .cpu_start (cpu_start),
      .busy      (busy),
      .err       (err)
   );

   // 50 MHz-style free-running clock
   always #5 clock_50M = ~clock_50M;

   // Record writes and run pulses away from the active edge
   always @(negedge clock_50M) begin
      if (mem_we) begin
         wAddr.push_back(mem_addr);
         wData.push_back(mem_wdata);
      end
      if (cpu_start) begin
         startCnt++;
         if (cpu_hold) startWithHold++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One received byte: ready low for a few cycles, then high with data
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clock_50M);
      rx_ready = 1'b0;
      repeat (3) @(negedge clock_50M);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (3) @(negedge clock_50M);
   endtask

   task automatic sendFrame();
      foreach (frm[i]) applyStimulus(frm[i]);
   endtask

   task automatic clearLog();
      wAddr.delete();
      wData.delete();
   endtask

   initial begin
      rst      = 1'b1;
      rx_ready = 1'b1;
      rx_data  = 8'h00;
      repeat (3) @(negedge clock_50M);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_hold", cpu_hold, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_addr", mem_addr, 16'h0000);
      checkOutput("rst_wdata", mem_wdata, 16'h0000);
      rst = 1'b0;

      // Idle line after reset must not produce any activity
      idleActivity = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock_50M);
         if (mem_we | cpu_hold | cpu_start | busy | err) idleActivity++;
      end
      checkOutput("idle_quiet", idleActivity, 0);

      // Good WRITE frame, two words at 0x1000
      clearLog();
      applyStimulus(8'hA5);
      checkOutput("sync_busy", busy, 1);
      checkOutput("sync_hold", cpu_hold, 0);
      applyStimulus(8'h01);
      checkOutput("cmd_hold", cpu_hold, 1);
      frm = '{8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
      sendFrame();
      checkOutput("w1_hold_mid", cpu_hold, 1);
      applyStimulus(8'hCD);
      checkOutput("w1_words_before_csum", wAddr.size(), 2);
      applyStimulus(8'h2F);
      checkOutput("w1_nwrites", wAddr.size(), 2);
      if (wAddr.size() == 2) begin
         checkOutput("w1_addr0", wAddr[0], 16'h1000);
         checkOutput("w1_data0", wData[0], 16'h1234);
         checkOutput("w1_addr1", wAddr[1], 16'h1001);
         checkOutput("w1_data1", wData[1], 16'hABCD);
      end
      checkOutput("w1_err", err, 0);
      checkOutput("w1_hold_end", cpu_hold, 0);
      checkOutput("w1_busy_end", busy, 0);
      checkOutput("w1_no_start", startCnt, 0);

      // Same frame with checksum off by one
      clearLog();
      frm = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
      sendFrame();
      checkOutput("w2_nwrites", wAddr.size(), 2);
      checkOutput("w2_err", err, 1);
      checkOutput("w2_busy", busy, 0);
      applyStimulus(8'hA5);
      checkOutput("w2_sync_clears_err", err, 0);

      // Good RUN frame (continues from the SYNC just sent)
      startBefore = startCnt;
      frm = '{8'h02, 8'hFE};
      sendFrame();
      checkOutput("run_pulses", startCnt - startBefore, 1);
      checkOutput("run_hold_at_start", startWithHold, 0);
      checkOutput("run_err", err, 0);
      checkOutput("run_hold_end", cpu_hold, 0);

      // RUN with bad checksum: no pulse, error set
      startBefore = startCnt;
      frm = '{8'hA5, 8'h02, 8'hFF};
      sendFrame();
      checkOutput("runbad_pulses", startCnt - startBefore, 0);
      checkOutput("runbad_err", err, 1);

      // Address wrap at 0xFFFF
      clearLog();
      frm = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h99};
      sendFrame();
      checkOutput("wrap_nwrites", wAddr.size(), 2);
      if (wAddr.size() == 2) begin
         checkOutput("wrap_addr0", wAddr[0], 16'hFFFF);
         checkOutput("wrap_data0", wData[0], 16'h1111);
         checkOutput("wrap_addr1", wAddr[1], 16'h0000);
         checkOutput("wrap_data1", wData[1], 16'h2222);
      end
      checkOutput("wrap_err", err, 0);

      // Zero-length write: checksum only, no writes
      clearLog();
      frm = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'hDF};
      sendFrame();
      checkOutput("len0_nwrites", wAddr.size(), 0);
      checkOutput("len0_err", err, 0);
      checkOutput("len0_busy", busy, 0);

      // Unknown command aborts with error
      frm = '{8'hA5, 8'h07};
      sendFrame();
      checkOutput("badcmd_err", err, 1);
      checkOutput("badcmd_busy", busy, 0);

      // Stall after ADDR_H: timeout after 100 quiet clocks
      frm = '{8'hA5, 8'h01, 8'h40};
      sendFrame();
      checkOutput("to_clears_err", err, 0);
      repeat (50) @(negedge clock_50M);
      checkOutput("to_still_busy", busy, 1);
      checkOutput("to_still_hold", cpu_hold, 1);
      repeat (60) @(negedge clock_50M);
      checkOutput("to_err", err, 1);
      checkOutput("to_busy", busy, 0);
      checkOutput("to_hold", cpu_hold, 0);

      // Async reset in the middle of a data word
      clearLog();
      frm = '{8'hA5, 8'h01, 8'h30, 8'h00, 8'h00, 8'h01, 8'h55};
      sendFrame();
      checkOutput("ar_hold_before", cpu_hold, 1);
      @(negedge clock_50M);
      rx_ready = 1'b0;
      rx_data  = 8'h66;
      repeat (2) @(negedge clock_50M);
      #2 rst = 1'b1;
      #1;
      checkOutput("ar_hold_now", cpu_hold, 0);
      checkOutput("ar_busy_now", busy, 0);
      checkOutput("ar_we_now", mem_we, 0);
      @(negedge clock_50M);
      rst      = 1'b0;
      rx_ready = 1'b1;
      repeat (5) @(negedge clock_50M);
      checkOutput("ar_nwrites", wAddr.size(), 0);
      checkOutput("ar_busy_after", busy, 0);
      checkOutput("ar_err_after", err, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/uart_loader.md
# uart_loader

Frame-level controller that sits behind `uart_rx`. It turns received bytes into program-memory writes and CPU run control for the ONC-16 core. It detects each completed byte from the receiver's `ready` rising edge and parses a fixed frame format. It holds the CPU while loading, writes 16-bit words sequentially into memory, verifies an 8-bit checksum, and issues a start pulse on a run command.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `CMD_WRITE`, 8'h01, write-block command
- `CMD_RUN`, 8'h02, run command
- `TIMEOUT`, 24'd5_000_000, max clocks between bytes inside a frame (100 ms at 50 MHz)

Ports:
- `clock_50M`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rx_ready`  in  1  `uart_rx` ready (1 = idle, 0 = receiving)
- `rx_data`  in  8  `uart_rx` data, valid on the cycle `rx_ready` rises
- `mem_we`  out  1  one-cycle write strobe
- `mem_addr`  out  16  word address
- `mem_wdata`  out  16  word data
- `cpu_hold`  out  1  CPU stall while a frame is in progress
- `cpu_start`  out  1  one-cycle run pulse
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky error flag; cleared by the next valid SYNC

## Operation
- Byte strobe: `byte_stb = rx_ready & ~ready_q`, where `ready_q` is registered and resets to 1. This prevents a false strobe after reset.
- Frame format: SYNC, CMD, then for WRITE only ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN words (each hi byte then lo byte), then CSUM.
- Checksum rule: the 8-bit sum of every byte from CMD through CSUM inclusive must equal 8'h00. SYNC is excluded.
- States: IDLE, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L, CSUM. Transitions occur only on `byte_stb` or on timeout.
- IDLE: SYNC moves to CMD and clears `err`. Any other byte is ignored.
- CMD:
  - WRITE moves to ADDR_H.
  - RUN moves to CSUM.
  - Any other value sets `err` and returns to IDLE.
- LEN_L: LEN = 0 moves to CSUM. Otherwise move to DATA_H.
- DATA_L: emits the word, increments the address, and decrements the remaining count.
  - Count reaching 0 moves to CSUM.
  - Otherwise return to DATA_H.
- CSUM, sum OK:
  - WRITE returns to IDLE.
  - RUN pulses `cpu_start` and returns to IDLE.
- CSUM, bad sum: sets `err`, returns to IDLE, and suppresses `cpu_start`.
  - Words already written are not undone.
  - Host software retries the whole frame.
- Address arithmetic: 16-bit, wraps 0xFFFF → 0x0000. LEN is a 16-bit count.
- Timeout: a 24-bit counter clears on every `byte_stb` and runs while not IDLE. Reaching TIMEOUT sets `err` and returns to IDLE.
- A SYNC byte mid-frame is treated as data; there is no resync.
- Reset: all state returns to IDLE.
  - Reset values: `mem_we`, `cpu_hold`, `cpu_start`, `busy`, `err` = 0.
  - `mem_addr` and `mem_wdata` = 0.

## Timing
- `mem_we` asserts for exactly 1 cycle, the cycle after the DATA_L `byte_stb`. `mem_addr` and `mem_wdata` are stable during that cycle.
- `cpu_hold` rises the cycle after the CMD-accept strobe. It falls in the same cycle the FSM re-enters IDLE, including on error or timeout.
- `cpu_start` is a single cycle, coincident with the IDLE re-entry after a good RUN checksum. `cpu_hold` is already 0 in that cycle.
- Byte throughput is ≥ 4340 clocks/byte at 115200 baud, so back-to-back strobes never occur. The FSM must still accept strobes on consecutive cycles.
- Reset asserted mid-frame drops `cpu_hold` and `mem_we` immediately (asynchronous). No partial write is emitted.

## Structure
- Shared header `loader_defs.vh` holds:
  - state encodings (4-bit localparams);
  - the SYNC and CMD constants;
  - the TIMEOUT default.
- One natural sub-module: `uart_byte_strobe`, the `rx_ready` edge detector plus data capture register. It is reusable by any future `uart_rx` consumer.
- The FSM, counters and checksum accumulator stay in `uart_loader`.

## Test plan
- Reset then idle line: `rx_ready` held 1 for 100 cycles → no `byte_stb`, all outputs 0.
- WRITE frame A5 01 10 00 00 02 12 34 AB CD, CSUM = 0x100 − (01+10+00+00+02+12+34+AB+CD mod 256) → writes 0x1000←0x1234 and 0x1001←0xABCD; `err` = 0; `cpu_hold` spans the frame.
- Same frame with CSUM off by 1 → both writes occur, `err` = 1; the next good SYNC clears `err`.
- RUN frame A5 02 FE → one `cpu_start` pulse, `err` = 0. RUN with CSUM FF → no pulse, `err` = 1.
- WRITE at addr FFFF, LEN 2 → writes at 0xFFFF then 0x0000. LEN 0 → no `mem_we`, CSUM accepted.
- Frame stalled after ADDR_H for TIMEOUT cycles (TIMEOUT overridden to 100 in the bench) → `err` = 1, IDLE, `cpu_hold` = 0. Async `rst` pulse mid-DATA → immediate IDLE, no `mem_we`.
